// File: rtl/light_chaser_gen.sv
// light_chaser_gen: WIDTH-bit LED pattern sequencer with a programmable step
// period and four motion modes (rotate left, rotate right, bounce, fill bar).
// light, step and wrap are all registered; no input reaches an output
// without passing through a flop.
module light_chaser_gen #(
    parameter int                 WIDTH        = 8,
    parameter int                 DIV_W        = 16,
    parameter logic [WIDTH-1:0]   INIT_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   div,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_pattern,
    output logic [WIDTH-1:0]   light,
    output logic               step,
    output logic               wrap
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] light_q, light_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    dir_e             dir_q,   dir_d;
    logic             step_q,  step_d;
    logic             wrap_q,  wrap_d;

    logic             end_hi;
    logic             end_lo;

    assign end_hi = light_q[WIDTH-1];
    assign end_lo = light_q[0];

    // State register: reset restores the power-on pattern and clears status.
    always_ff @(posedge clk) begin
        if (rst) begin
            light_q <= INIT_PATTERN;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            light_q <= light_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: load beats stepping; a step fires once the prescaler
    // count has reached div (also when div was lowered below the count).
    always_comb begin
        light_d = light_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        if (load) begin
            light_d = load_pattern;
            cnt_d   = '0;
            dir_d   = DIR_LEFT;
        end else if (enable) begin
            if (cnt_q >= div) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode)
                    MODE_ROL: begin
                        light_d = {light_q[WIDTH-2:0], light_q[WIDTH-1]};
                        wrap_d  = end_hi;
                    end
                    MODE_ROR: begin
                        light_d = {light_q[0], light_q[WIDTH-1:1]};
                        wrap_d  = end_lo;
                    end
                    MODE_BOUNCE: begin
                        if (end_hi && end_lo) begin
                            // Both ends lit: nowhere to go, just turn around.
                            dir_d  = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                            wrap_d = 1'b1;
                        end else if (dir_q == DIR_LEFT) begin
                            if (end_hi) begin
                                dir_d   = DIR_RIGHT;
                                light_d = light_q >> 1;
                                wrap_d  = 1'b1;
                            end else begin
                                light_d = light_q << 1;
                            end
                        end else begin
                            if (end_lo) begin
                                dir_d   = DIR_LEFT;
                                light_d = light_q << 1;
                                wrap_d  = 1'b1;
                            end else begin
                                light_d = light_q >> 1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (&light_q) begin
                            light_d = LSB_ONE;
                            wrap_d  = 1'b1;
                        end else begin
                            light_d = (light_q << 1) | LSB_ONE;
                        end
                    end
                    default: begin
                        light_d = light_q;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign light = light_q;
    assign step  = step_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_light_chaser_gen.sv
// Scoreboard bench for light_chaser_gen (WIDTH=8, DIV_W=16): a driver issues
// one set of inputs per cycle and queues the reference model's prediction;
// a monitor pops and compares every cycle the DUT presents its outputs.
module tb_light_chaser_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] div;
    logic        load;
    logic [7:0]  load_pattern;
    logic [7:0]  light;
    logic        step;
    logic        wrap;

    light_chaser_gen #(
        .WIDTH (8),
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .div          (div),
        .load         (load),
        .load_pattern (load_pattern),
        .light        (light),
        .step         (step),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int light;
        int step;
        int wrap;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cycno = 0;

    // Reference model state: plain integers, direction as +1 (left) / -1 (right).
    int m_light;
    int m_cnt;
    int m_dir;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycno, got, want);
        end
    endtask

    function automatic int shift_dir(input int v, input int d);
        if (d > 0) return (v * 2) % 256;
        return v / 2;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic cyc(input int r, input int e, input int m, input int d,
                       input int l, input int p);
        exp_t x;
        int   top;
        int   bot;
        int   lead;
        @(negedge clk);
        rst          = r[0];
        enable       = e[0];
        mode         = m[1:0];
        div          = d[15:0];
        load         = l[0];
        load_pattern = p[7:0];
        x.step = 0;
        x.wrap = 0;
        if (r != 0) begin
            m_light = 1;
            m_cnt   = 0;
            m_dir   = 1;
        end else if (l != 0) begin
            m_light = p % 256;
            m_cnt   = 0;
            m_dir   = 1;
        end else if (e != 0) begin
            if (m_cnt >= d) begin
                m_cnt  = 0;
                x.step = 1;
                top = (m_light >= 128) ? 1 : 0;
                bot = m_light % 2;
                case (m)
                    0: begin
                        x.wrap  = top;
                        m_light = (m_light * 2) % 256 + top;
                    end
                    1: begin
                        x.wrap  = bot;
                        m_light = m_light / 2 + bot * 128;
                    end
                    2: begin
                        lead = (m_dir > 0) ? top : bot;
                        if (top == 1 && bot == 1) begin
                            m_dir  = -m_dir;
                            x.wrap = 1;
                        end else if (lead == 1) begin
                            m_dir   = -m_dir;
                            x.wrap  = 1;
                            m_light = shift_dir(m_light, m_dir);
                        end else begin
                            m_light = shift_dir(m_light, m_dir);
                        end
                    end
                    default: begin
                        if (m_light == 255) begin
                            m_light = 1;
                            x.wrap  = 1;
                        end else begin
                            m_light = (m_light * 2 + 1) % 256;
                        end
                    end
                endcase
            end else begin
                m_cnt++;
            end
        end
        x.light = m_light;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, so compare after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                cycno++;
                check("light", int'(light), x.light);
                check("step",  int'(step),  x.step);
                check("wrap",  int'(wrap),  x.wrap);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'b00; div = 16'd0;
        load = 1'b0; load_pattern = 8'h00;
        m_light = 1; m_cnt = 0; m_dir = 1;

        // Reset, then rotate left with a 5-cycle period.
        cyc(1, 0, 0, 4, 0, 0);
        for (int i = 0; i < 45; i++) cyc(0, 1, 0, 4, 0, 0);

        // Rotate right from 81 at full rate.
        cyc(0, 1, 1, 0, 1, 'h81);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, 0);

        // Bounce from 01, then from 81 (both ends lit).
        cyc(0, 1, 2, 0, 1, 'h01);
        for (int i = 0; i < 20; i++) cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 1, 2, 0, 1, 'h81);
        for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0, 0, 0);

        // Fill bar with div=1, then a zero pattern.
        cyc(0, 1, 3, 1, 1, 'h01);
        for (int i = 0; i < 20; i++) cyc(0, 1, 3, 1, 0, 0);
        cyc(0, 1, 3, 1, 1, 'h00);
        for (int i = 0; i < 2; i++) cyc(0, 1, 3, 1, 0, 0);

        // div=9: freeze at count=7, resume, then shrink div below the count.
        cyc(0, 1, 0, 9, 1, 'h01);
        for (int i = 0; i < 7; i++)  cyc(0, 1, 0, 9, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 9, 0, 0);
        for (int i = 0; i < 3; i++)  cyc(0, 1, 0, 9, 0, 0);
        for (int i = 0; i < 7; i++)  cyc(0, 1, 0, 9, 0, 0);
        cyc(0, 1, 0, 2, 0, 0);
        cyc(0, 1, 0, 2, 0, 0);

        // Load collides with a due step; then reset while disabled.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 'h5A);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 0);
        cyc(1, 0, 2, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 0);

        // Randomised traffic across all modes and small periods.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 59) == 0) ? 1 : 0,
                ($urandom_range(0, 9) < 8) ? 1 : 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)),
                ($urandom_range(0, 11) == 0) ? 1 : 0,
                int'($urandom_range(0, 255)));
        end

        // Let the monitor drain the last prediction, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
